// File: rtl/readout_packet_receiver.sv
// readout_packet_receiver
//   Receive end of the chip read-out serial link. Deframes packets arriving
//   MSB first on dat_i (start bit, chip ID, payload), stores them in a
//   first-word-fall-through FIFO and throttles the sender through xoff_o.
//   The FIFO head is offered on a valid/ready port with the register-read
//   fields decoded.
// Ports
//   clk          serial bit clock, everything sampled on posedge
//   rst          synchronous reset, active-high
//   en           receiver enable; low holds the deframer idle
//   dat_i        serial data, idle level 0
//   xoff_o       registered flow-control to the sender (1 = stop)
//   out_valid    FIFO head holds a packet
//   out_ready    consumer accepts the head when out_valid is high
//   out_id       chip ID of the head packet
//   out_payload  payload of the head packet
//   out_is_reg   head payload type is a register read (4'b1000)
//   out_reg_addr register address field of the head payload
//   out_reg_serr register soft-error flag of the head payload
//   out_reg_data register data field of the head payload
//   overflow     sticky: a completed packet was dropped on a full FIFO
//   pkt_count    packets written into the FIFO, wraps around
module readout_packet_receiver #(
   parameter int unsigned ID_WIDTH      = 5,
   parameter int unsigned PAYLOAD_WIDTH = 54,
   parameter int unsigned LOG_DEPTH     = 3,
   parameter int unsigned XOFF_MARGIN   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     dat_i,
   output logic                     xoff_o,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ID_WIDTH-1:0]      out_id,
   output logic [PAYLOAD_WIDTH-1:0] out_payload,
   output logic                     out_is_reg,
   output logic [6:0]               out_reg_addr,
   output logic                     out_reg_serr,
   output logic [31:0]              out_reg_data,
   output logic                     overflow,
   output logic [15:0]              pkt_count
);

   localparam int unsigned WORD_W = ID_WIDTH + PAYLOAD_WIDTH;
   localparam int unsigned CNT_W  = $clog2(WORD_W);
   localparam int unsigned DEPTH  = 2 ** LOG_DEPTH;

   localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(WORD_W - 1);
   localparam logic [LOG_DEPTH:0] FULL_LEVEL = (LOG_DEPTH + 1)'(DEPTH);
   localparam logic [LOG_DEPTH:0] XOFF_LEVEL = (LOG_DEPTH + 1)'(DEPTH - XOFF_MARGIN);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    bit_cnt;
   // The final bit is taken straight from dat_i on the write edge, so only
   // WORD_W-1 bits ever need to be held.
   logic [WORD_W-2:0]   shreg;

   logic                wr_req;
   logic [WORD_W-1:0]   wr_word;

   logic [WORD_W-1:0]   mem [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr;
   logic [LOG_DEPTH-1:0] rd_ptr;
   logic [LOG_DEPTH:0]  occ;
   logic [LOG_DEPTH:0]  occ_next;
   logic                full;
   logic                pop;
   logic                wr_ok;
   logic                drop;
   logic [WORD_W-1:0]   head;

   //------------------------------------------------------------------
   // Deframer
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en && dat_i) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               if (!en) begin
                  state <= IDLE;
               end else begin
                  shreg <= {shreg[WORD_W-3:0], dat_i};
                  if (bit_cnt == LAST_BIT) begin
                     state <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write strobe is asserted during the cycle whose edge samples the last bit.
   assign wr_req  = (state == SHIFT) && en && (bit_cnt == LAST_BIT);
   assign wr_word = {shreg, dat_i};

   //------------------------------------------------------------------
   // Packet FIFO
   //------------------------------------------------------------------
   assign full      = (occ == FULL_LEVEL);
   assign out_valid = (occ != '0);
   assign pop       = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign wr_ok     = wr_req && (!full || pop);
   assign drop      = wr_req && full && !pop;

   always_comb begin
      occ_next = occ;
      case ({wr_ok, pop})
         2'b10:   occ_next = occ + 1'b1;
         2'b01:   occ_next = occ - 1'b1;
         default: occ_next = occ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         xoff_o    <= 1'b0;
         overflow  <= 1'b0;
         pkt_count <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr    <= wr_ptr + 1'b1;
            pkt_count <= pkt_count + 16'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         occ    <= occ_next;
         xoff_o <= (occ_next >= XOFF_LEVEL);
      end
   end

   //------------------------------------------------------------------
   // Head presentation and register-read decode (zero when empty)
   //------------------------------------------------------------------
   assign head = mem[rd_ptr];

   always_comb begin
      out_id       = '0;
      out_payload  = '0;
      out_is_reg   = 1'b0;
      out_reg_addr = '0;
      out_reg_serr = 1'b0;
      out_reg_data = '0;
      if (out_valid) begin
         out_id       = head[WORD_W-1 -: ID_WIDTH];
         out_payload  = head[PAYLOAD_WIDTH-1:0];
         out_is_reg   = (head[53:50] == 4'b1000);
         out_reg_addr = head[48:42];
         out_reg_serr = head[49];
         out_reg_data = head[33:2];
      end
   end

endmodule

// File: tb/tb_readout_packet_receiver.sv
// tb_readout_packet_receiver
//   Self-checking bench for readout_packet_receiver. Frames are serialised
//   bit by bit; every frame that should reach the FIFO is queued and compared
//   against the head when the consumer accepts it.
module tb_readout_packet_receiver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        dat_i = 1'b0;
   logic        out_ready = 1'b0;
   logic        xoff_o;
   logic        out_valid;
   logic [4:0]  out_id;
   logic [53:0] out_payload;
   logic        out_is_reg;
   logic [6:0]  out_reg_addr;
   logic        out_reg_serr;
   logic [31:0] out_reg_data;
   logic        overflow;
   logic [15:0] pkt_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [58:0] sb_q[$];
   logic [58:0] exp_word;

   readout_packet_receiver #(
      .ID_WIDTH      (5),
      .PAYLOAD_WIDTH (54),
      .LOG_DEPTH     (3),
      .XOFF_MARGIN   (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .dat_i        (dat_i),
      .xoff_o       (xoff_o),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_id       (out_id),
      .out_payload  (out_payload),
      .out_is_reg   (out_is_reg),
      .out_reg_addr (out_reg_addr),
      .out_reg_serr (out_reg_serr),
      .out_reg_data (out_reg_data),
      .overflow     (overflow),
      .pkt_count    (pkt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      dat_i = b;
      tick();
   endtask

   task automatic send_frame(input logic [4:0] id, input logic [53:0] pl,
                             input bit push, input bit ready_last);
      logic [59:0] f;
      f = {1'b1, id, pl};
      for (int i = 59; i >= 0; i--) begin
         if (i == 0 && ready_last) out_ready = 1'b1;
         send_bit(f[i]);
      end
      dat_i = 1'b0;
      if (ready_last) out_ready = 1'b0;
      if (push) sb_q.push_back({id, pl});
   endtask

   function automatic logic [53:0] rnd_pl(input bit reg_type);
      logic [63:0] r;
      logic [53:0] p;
      r = {$urandom, $urandom};
      p = r[53:0];
      if (reg_type) p[53:50] = 4'b1000;
      else if (p[53:50] == 4'b1000) p[53:50] = 4'b0001;
      return p;
   endfunction

   task automatic apply_reset();
      rst = 1'b1;
      en = 1'b1;
      dat_i = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic drain(input string tag, input int limit);
      out_ready = 1'b1;
      for (int i = 0; i < limit; i++) begin
         if (sb_q.size() == 0) break;
         tick();
      end
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
      tick();
      check({tag, "_valid_low"}, 64'(out_valid), 64'd0);
   endtask

   // Scoreboard: the head is accepted on the next edge whenever valid & ready.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            exp_word = sb_q.pop_front();
            check("id",       64'(out_id),       64'(exp_word[58:54]));
            check("payload",  64'(out_payload),  64'(exp_word[53:0]));
            check("is_reg",   64'(out_is_reg),   64'(exp_word[53:50] == 4'b1000));
            check("reg_addr", 64'(out_reg_addr), 64'(exp_word[48:42]));
            check("reg_serr", 64'(out_reg_serr), 64'(exp_word[49]));
            check("reg_data", 64'(out_reg_data), 64'(exp_word[33:2]));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      logic [53:0] pl;
      logic [59:0] f;

      // Reset state
      rst = 1'b1;
      tick();
      apply_reset();
      check("rst_valid",    64'(out_valid),   64'd0);
      check("rst_xoff",     64'(xoff_o),      64'd0);
      check("rst_overflow", 64'(overflow),    64'd0);
      check("rst_count",    64'(pkt_count),   64'd0);
      check("rst_id",       64'(out_id),      64'd0);
      check("rst_payload",  64'(out_payload), 64'd0);

      // 1: single register-read frame
      out_ready = 1'b1;
      pl = {4'b1000, 1'b0, 7'h3f, 8'h00, 32'hDEADBEEF, 2'b00};
      send_frame(5'h0A, pl, 1'b1, 1'b0);
      check("t1_valid",    64'(out_valid),    64'd1);
      check("t1_id",       64'(out_id),       64'h0A);
      check("t1_is_reg",   64'(out_is_reg),   64'd1);
      check("t1_reg_addr", 64'(out_reg_addr), 64'h3f);
      check("t1_reg_data", 64'(out_reg_data), 64'hDEADBEEF);
      check("t1_count",    64'(pkt_count),    64'd1);
      drain("t1", 20);

      // 2: three back-to-back frames
      apply_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) send_frame(5'(k + 3), rnd_pl(k == 1), 1'b1, 1'b0);
      drain("t2", 20);
      check("t2_count", 64'(pkt_count), 64'd3);

      // 3: fill with consumer stalled, overflow, then drain
      apply_reset();
      for (int k = 0; k < 5; k++) send_frame(5'(k), rnd_pl(k[0]), 1'b1, 1'b0);
      check("t3_xoff_5", 64'(xoff_o), 64'd0);
      send_frame(5'd5, rnd_pl(1'b0), 1'b1, 1'b0);
      check("t3_xoff_6", 64'(xoff_o), 64'd1);
      send_frame(5'd6, rnd_pl(1'b1), 1'b1, 1'b0);
      send_frame(5'd7, rnd_pl(1'b0), 1'b1, 1'b0);
      check("t3_count_8",   64'(pkt_count), 64'd8);
      check("t3_no_ovf",    64'(overflow),  64'd0);
      send_frame(5'd8, rnd_pl(1'b1), 1'b0, 1'b0);
      check("t3_overflow",  64'(overflow),  64'd1);
      check("t3_count_ovf", 64'(pkt_count), 64'd8);
      out_ready = 1'b1;
      tick();
      check("t3_xoff_occ7", 64'(xoff_o), 64'd1);
      tick();
      check("t3_xoff_occ6", 64'(xoff_o), 64'd1);
      tick();
      check("t3_xoff_occ5", 64'(xoff_o), 64'd0);
      drain("t3", 20);
      check("t3_ovf_sticky", 64'(overflow), 64'd1);

      // 4: write on full coinciding with a pop
      apply_reset();
      for (int k = 0; k < 8; k++) send_frame(5'(k + 16), rnd_pl(k[0]), 1'b1, 1'b0);
      send_frame(5'd31, rnd_pl(1'b1), 1'b1, 1'b1);
      check("t4_no_ovf", 64'(overflow),  64'd0);
      check("t4_count",  64'(pkt_count), 64'd9);
      drain("t4", 20);

      // 5: reset mid-frame, then a clean frame
      apply_reset();
      out_ready = 1'b1;
      f = {1'b1, 5'h11, rnd_pl(1'b0)};
      for (int i = 59; i >= 30; i--) send_bit(f[i]);
      rst = 1'b1;
      dat_i = 1'b0;
      tick();
      rst = 1'b0;
      send_frame(5'h12, rnd_pl(1'b1), 1'b1, 1'b0);
      drain("t5", 20);
      check("t5_count",    64'(pkt_count), 64'd1);
      check("t5_overflow", 64'(overflow),  64'd0);

      // 6: disabled receiver, then enable dropped mid-frame
      apply_reset();
      out_ready = 1'b1;
      en = 1'b0;
      for (int i = 0; i < 80; i++) send_bit(1'($urandom));
      check("t6_count_dis", 64'(pkt_count), 64'd0);
      check("t6_valid_dis", 64'(out_valid), 64'd0);
      en = 1'b1;
      f = {1'b1, 5'h05, rnd_pl(1'b0)};
      for (int i = 59; i >= 40; i--) send_bit(f[i]);
      en = 1'b0;
      send_bit(1'b0);
      en = 1'b1;
      send_frame(5'h06, rnd_pl(1'b1), 1'b1, 1'b0);
      drain("t6", 20);
      check("t6_count", 64'(pkt_count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
